// File: rtl/rc4_ksa_shuffler.sv
// RC4 key-scheduling stage: swaps S[i] and S[j] for i = 0..255 over a shared 256x8 S-RAM.
// Optional macro KSA_INIT_EN adds an INIT phase that first writes S[i] = i.
module rc4_ksa_shuffler #(
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned KEY_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Shuffle_A_Start,
  input  logic                 Finish_ack,
  input  logic [KEY_WIDTH-1:0] secret_key,
  input  logic [7:0]           q_S,
  output logic [7:0]           Address_S,
  output logic [7:0]           data_S,
  output logic                 wren_S,
  output logic                 Busy,
  output logic                 Shuffle_A_Finish,
  output logic [7:0]           states
);

  localparam int unsigned KidxW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [3:0] {
    StIdle   = 4'h0,
    StInit   = 4'h1,
    StReadI  = 4'h2,
    StWaitI  = 4'h3,
    StCalcJ  = 4'h4,
    StReadJ  = 4'h5,
    StWaitJ  = 4'h6,
    StLatchJ = 4'h7,
    StWriteI = 4'h8,
    StWriteJ = 4'h9,
    StDone   = 4'hA
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       i_q, i_d;
  logic [7:0]       j_q, j_d;
  logic [7:0]       si_q, si_d;
  logic [7:0]       sj_q, sj_d;
  logic [KidxW-1:0] kidx_q, kidx_d;
  logic [7:0]       key_byte;

  // Byte 0 of the key is the most significant byte.
  always_comb begin
    key_byte = '0;
    for (int k = 0; k < int'(KEY_BYTES); k++) begin
      if (kidx_q == KidxW'(k)) begin
        key_byte = secret_key[8*(int'(KEY_BYTES)-k)-1 -: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    kidx_d  = kidx_q;
    unique case (state_q)
      StIdle: begin
        if (Shuffle_A_Start) begin
          i_d    = '0;
          j_d    = '0;
          kidx_d = '0;
`ifdef KSA_INIT_EN
          state_d = StInit;
`else
          state_d = StReadI;
`endif
        end
      end
`ifdef KSA_INIT_EN
      StInit: begin
        i_d = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          state_d = StReadI;
        end
      end
`endif
      StReadI: state_d = StWaitI;
      StWaitI: state_d = StCalcJ;
      StCalcJ: begin
        si_d    = q_S;
        j_d     = j_q + q_S + key_byte;
        state_d = StReadJ;
      end
      StReadJ:  state_d = StWaitJ;
      StWaitJ:  state_d = StLatchJ;
      StLatchJ: begin
        sj_d    = q_S;
        state_d = StWriteI;
      end
      StWriteI: state_d = StWriteJ;
      StWriteJ: begin
        if (i_q == 8'hFF) begin
          state_d = StDone;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == KidxW'(KEY_BYTES - 1)) ? '0 : kidx_q + KidxW'(1);
          state_d = StReadI;
        end
      end
      StDone: begin
        if (Finish_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      kidx_q  <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      kidx_q  <= kidx_d;
    end
  end

  // Outputs depend only on registers; WRITE_J after WRITE_I makes a self-swap land on si.
  always_comb begin
    Address_S        = '0;
    data_S           = '0;
    wren_S           = 1'b0;
    Busy             = (state_q != StIdle);
    Shuffle_A_Finish = (state_q == StDone);
    states           = {4'h0, state_q};
    unique case (state_q)
      StInit: begin
        Address_S = i_q;
        data_S    = i_q;
        wren_S    = 1'b1;
      end
      StReadI, StWaitI: Address_S = i_q;
      StReadJ, StWaitJ: Address_S = j_q;
      StWriteI: begin
        Address_S = i_q;
        data_S    = sj_q;
        wren_S    = 1'b1;
      end
      StWriteJ: begin
        Address_S = j_q;
        data_S    = si_q;
        wren_S    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_ksa_shuffler.sv
// Scoreboard bench for rc4_ksa_shuffler with a two-cycle-latency S-RAM model.
module tb_rc4_ksa_shuffler;

`ifdef KSA_INIT_EN
  localparam bit InitEn = 1'b1;
`else
  localparam bit InitEn = 1'b0;
`endif
  localparam int Latency = InitEn ? 2304 : 2048;
  localparam int WrOff   = InitEn ? 256 : 0;

  typedef struct {
    string          name;
    int             start_edge;
    int             lat;
    logic [2047:0]  s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ack;
  logic [23:0] key;
  logic [7:0]  q_s;
  logic [7:0]  addr;
  logic [7:0]  data;
  logic        wren;
  logic        busy;
  logic        fin;
  logic [7:0]  states;

  logic [7:0]    mem [256];
  logic [7:0]    addr_r;
  logic          load_req = 1'b0;
  logic [2047:0] load_img;
  logic [15:0]   wlog [$];
  exp_t          sb [$];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  rc4_ksa_shuffler #(.KEY_BYTES(3), .KEY_WIDTH(24)) dut (
    .clk              (clk),
    .rst              (rst),
    .Shuffle_A_Start  (start),
    .Finish_ack       (ack),
    .secret_key       (key),
    .q_S              (q_s),
    .Address_S        (addr),
    .data_S           (data),
    .wren_S           (wren),
    .Busy             (busy),
    .Shuffle_A_Finish (fin),
    .states           (states)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // S-RAM: address registered, then data registered -> valid two edges after address.
  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < 256; k++) mem[k] <= load_img[8*k +: 8];
      wlog.delete();
    end else if (wren) begin
      mem[addr] <= data;
      wlog.push_back({addr, data});
    end
    addr_r <= addr;
    q_s    <= mem[addr_r];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2047:0] identity();
    logic [2047:0] r;
    for (int n = 0; n < 256; n++) r[8*n +: 8] = 8'(n);
    return r;
  endfunction

  function automatic logic [2047:0] reversed();
    logic [2047:0] r;
    for (int n = 0; n < 256; n++) r[8*n +: 8] = 8'(255 - n);
    return r;
  endfunction

  function automatic logic [2047:0] ksa_model(input logic [2047:0] img, input logic [23:0] k);
    logic [7:0]    s [256];
    logic [7:0]    kb [3];
    logic [7:0]    j;
    logic [7:0]    t;
    logic [2047:0] r;
    for (int n = 0; n < 256; n++) s[n] = InitEn ? 8'(n) : img[8*n +: 8];
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    j = 8'd0;
    for (int n = 0; n < 256; n++) begin
      j = j + s[n] + kb[n % 3];
      t = s[n];
      s[n] = s[j];
      s[j] = t;
    end
    for (int n = 0; n < 256; n++) r[8*n +: 8] = s[n];
    return r;
  endfunction

  function automatic logic [15:0] wget(input int idx);
    if (idx < wlog.size()) return wlog[idx];
    return 16'hxxxx;
  endfunction

  task automatic load(input logic [2047:0] img);
    @(negedge clk);
    load_img = img;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic do_start(input string nm, input logic [23:0] k, input logic [2047:0] img,
                          input bit push);
    exp_t e;
    key = k;
    load(img);
    start = 1'b1;
    e.name       = nm;
    e.start_edge = cyc + 1;
    e.lat        = Latency;
    e.s          = ksa_model(img, k);
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_fin(input string nm);
    bit ok = 1'b0;
    int n = 0;
    while (!ok && n < Latency + 100) begin
      @(negedge clk);
      n++;
      if (fin) ok = 1'b1;
    end
    check({nm, " finish_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic ack_done(input string nm);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check({nm, " idle_finish"}, 32'(fin), 32'd0);
    check({nm, " idle_busy"}, 32'(busy), 32'd0);
    check({nm, " idle_states"}, 32'(states), 32'd0);
  endtask

  task automatic monitor();
    exp_t         e;
    logic         fin_prev = 1'b0;
    logic [255:0] seen;
    forever begin
      @(negedge clk);
      if (fin && !fin_prev) begin
        check("sb_pending_at_finish", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check({e.name, " latency"}, 32'(cyc - e.start_edge), 32'(e.lat));
          seen = '0;
          for (int k = 0; k < 256; k++) begin
            check($sformatf("%s s[%0d]", e.name, k), 32'(mem[k]), 32'(e.s[8*k +: 8]));
            seen[mem[k]] = 1'b1;
          end
          check({e.name, " distinct"}, 32'($countones(seen)), 32'd256);
        end
      end
      fin_prev = fin;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ack   = 1'b0;
    key   = '0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({addr, data, wren, busy, fin, states}), 32'd0);
    rst = 1'b0;

    // Idle with no start: everything stays quiet.
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check($sformatf("idle_outputs c%0d", c), 32'({addr, data, wren, busy, fin, states}),
            32'd0);
    end

    // Key 000249: i=0 self-swaps at 0, i=1 swaps with j=3.
    do_start("k000249", 24'h000249, identity(), 1'b1);
    wait_fin("k000249");
    check("k000249 write_count", 32'(wlog.size()), 32'(WrOff + 512));
    check("k000249 w0", 32'(wget(WrOff + 0)), 32'h0000);
    check("k000249 w1", 32'(wget(WrOff + 1)), 32'h0000);
    check("k000249 w2", 32'(wget(WrOff + 2)), 32'h0103);
    check("k000249 w3", 32'(wget(WrOff + 3)), 32'h0301);
    ack_done("k000249");

    // Key 0 on identity: j==i at both i=0 and i=1.
    do_start("k000000", 24'h000000, identity(), 1'b1);
    wait_fin("k000000");
    check("k000000 w2", 32'(wget(WrOff + 2)), 32'h0101);
    check("k000000 w3", 32'(wget(WrOff + 3)), 32'h0101);
    ack_done("k000000");

    do_start("rev010203", 24'h010203, reversed(), 1'b1);
    wait_fin("rev010203");
    ack_done("rev010203");

    // Handshake: stray start/ack while busy, then a long-held DONE.
    do_start("hs5a3c96", 24'h5A3C96, identity(), 1'b1);
    repeat (100) @(negedge clk);
    start = 1'b1;
    ack   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ack   = 1'b0;
    wait_fin("hs5a3c96");
    repeat (20) @(negedge clk);
    check("hs held_finish", 32'(fin), 32'd1);
    check("hs held_busy", 32'(busy), 32'd1);
    ack_done("hs5a3c96");

    // Asynchronous reset mid-shuffle, then a clean restart.
    do_start("abort", 24'h000249, identity(), 1'b0);
    repeat (1000) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("midreset_outputs", 32'({addr, data, wren, busy, fin, states}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_start("restart", 24'h000249, identity(), 1'b1);
    wait_fin("restart");
    ack_done("restart");

    do_start("kffffff", 24'hFFFFFF, identity(), 1'b1);
    wait_fin("kffffff");
    ack_done("kffffff");

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rc4_ksa_shuffler.md
Name: rc4_ksa_shuffler

Overview:
- RC4 key-scheduling stage. Sits directly upstream of the PRGA/decrypt FSM (Shuffler_B).
- Optionally initialises S-RAM to s[i]=i, then performs the KSA swap loop over the shared 256x8 S memory with the current secret key.
- Signals completion with a Finish/Finish_ack handshake so the key-search controller can start the downstream decrypt stage.
- Owns the S-RAM port only while busy; the top-level mux selects it by Busy.

Parameters:
KEY_BYTES, 3, number of secret-key bytes; key index wraps modulo KEY_BYTES.
KEY_WIDTH, 24, width of secret_key; must equal 8*KEY_BYTES.

Ports:
clk  input  1  single system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
Shuffle_A_Start  input  1  one-cycle start pulse; sampled only in IDLE.
Finish_ack  input  1  acknowledge from controller; releases DONE.
secret_key  input  KEY_WIDTH  key; byte k = secret_key[8*(KEY_BYTES-k)-1 -: 8]; byte 0 is MSB; must be stable while Busy.
q_S  input  8  S-RAM read data; synchronous read, valid on the second rising edge after Address_S is driven.
Address_S  output  8  S-RAM address.
data_S  output  8  S-RAM write data.
wren_S  output  1  S-RAM write enable.
Busy  output  1  high from start accept until DONE is exited.
Shuffle_A_Finish  output  1  high in DONE.
states  output  8  debug state encoding; IDLE = 8'h00.

Behaviour:
- Reset (async, any time, including mid-shuffle) sets state=IDLE, i=0, j=0, key index=0, si=0, sj=0. All outputs 0.
- After a mid-shuffle reset, S contents are undefined; the controller must restart this block.
- IDLE: all outputs 0. Shuffle_A_Start=1 moves to INIT (when the macro is defined) or READ_I, with i=0, j=0, kidx=0.
- INIT: Address_S=i, data_S=i, wren_S=1 for one cycle per address.
  - 256 cycles total, i = 0..255.
  - After the write at i=255, i wraps to 0 and the FSM enters READ_I.
- Shuffle loop, 8 cycles per i:
  - READ_I: Address_S=i, wren_S=0.
  - WAIT_I: Address_S held at i.
  - CALC_J: si<=q_S; j<=j+q_S+key_byte[kidx]. The sum is mod 256; carries are discarded.
  - READ_J: Address_S=j.
  - WAIT_J: Address_S held at j.
  - LATCH_J: sj<=q_S.
  - WRITE_I: Address_S=i, data_S=sj, wren_S=1.
  - WRITE_J: Address_S=j, data_S=si, wren_S=1.
    - If i==255, go to DONE.
    - Otherwise i<=i+1, kidx<=(kidx==KEY_BYTES-1)?0:kidx+1, and go to READ_I.
- i==j: both writes hit the same address; the final value is si, which is a correct self-swap.
- wren_S is high only in INIT, WRITE_I and WRITE_J. It is never high for two different addresses in one cycle.
- DONE: Shuffle_A_Finish=1, Busy=1. Held until Finish_ack=1, then IDLE on the next edge with Finish low.
- Shuffle_A_Start is ignored outside IDLE. Finish_ack is ignored outside DONE.
- Latency, start pulse edge to Finish high:
  - with init: 256 + 2048 = 2304 cycles;
  - without init: 2048 cycles.
- Outputs are decoded from the state register plus the i/j/si/sj registers. No combinational path from inputs to outputs.

Optional Feature:
- Macro: KSA_INIT_EN.
- Defined: the INIT phase writes s[i]=i before shuffling (latency 2304).
- Not defined: no INIT state. S must already hold the identity permutation (loaded by a separate init FSM or MIF). Start goes directly to READ_I (latency 2048).

Test Plan:
1. Reset then idle:
   - rst pulse, Start low -> all outputs 0; states=8'h00; Busy=0 for 50 cycles.
2. Start with KSA_INIT_EN, secret_key=24'h000249, behavioural RAM model:
   - i=0 -> j=0, self-swap, s[0]=0.
   - i=1 -> j=3, s[1]=3, s[3]=1.
   - Final 256-byte S matches the software KSA model.
   - Finish rises 2304 cycles after the Start edge.
3. Self-swap, RAM preloaded so j==i at some step -> WRITE_I and WRITE_J share an address; final s[i]=si; permutation still valid (all 256 values unique).
4. Handshake:
   - Finish_ack held low 20 cycles after DONE -> Finish stays 1.
   - Ack pulse -> IDLE next edge; Finish=0, Busy=0.
   - Start pulsed during busy -> no effect on sequence or latency.
5. Reset mid-operation: assert rst at cycle 1000 -> immediately IDLE, outputs 0; a fresh Start completes normally with the correct S.
6. Without the macro, identity-preloaded RAM, key 24'hFFFFFF -> Finish at exactly 2048 cycles; S matches the model.
